dqsw_delay_trainer: RTL and testbench

Sequencer for one DDR4 DQSW training lane IOD: it drives the lane's dynamic delay-line controls (LOAD/MOVE/DIRECTION) and eye-monitor flag clear. It sweeps the DQS write delay tap by tap, and majority-samples the registered 2-bit RX data at each tap. It stops at the first 0→1 transition and reports the tap index. It sits between the DDR PHY training FSM (start/abort/result) and the per-lane IOD delay-line ports, in the FAB_CLK domain.

---
 rtl/dqsw_delay_trainer.sv | 209 ++++++++++++++++++++
 tb/tb_dqsw_delay_trainer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dqsw_delay_trainer.sv
// DQSW write-leveling tap sweeper for one DDR4 lane IOD.
// Steps the DQS write delay one tap at a time, majority-votes the 2-bit RX
// sample at each tap and stops at the first 0->1 transition of the vote.
module dqsw_delay_trainer #(
   parameter int MAX_TAPS      = 128,
   parameter int SETTLE_CYCLES = 8,
   parameter int SAMPLES       = 4
) (
   input  logic       FAB_CLK,
   input  logic       ARST_N,
   input  logic       START,
   input  logic       ABORT,
   input  logic [1:0] RX_DATA_0,
   input  logic       DELAY_LINE_OUT_OF_RANGE_0,
   input  logic       EYE_MONITOR_EARLY_0,
   input  logic       EYE_MONITOR_LATE_0,
   output logic       DELAY_LINE_LOAD_0,
   output logic       DELAY_LINE_MOVE_0,
   output logic       DELAY_LINE_DIRECTION_0,
   output logic       EYE_MONITOR_CLEAR_FLAGS_0,
   output logic       BUSY,
   output logic       DONE,
   output logic       FAIL,
   output logic [7:0] TAP_RESULT,
   output logic [1:0] EYE_FLAGS
);

   localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   // One spare bit keeps the ones counter at least 3 bits wide for any SAMPLES.
   localparam int ONES_W  = $clog2(2 * SAMPLES + 1) + 1;

   localparam logic [7:0]        LAST_TAP    = 8'(MAX_TAPS - 1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLES - 1);
   localparam logic [ONES_W-1:0] ONES_THRESH = ONES_W'(SAMPLES);

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_LOAD   = 4'd1,
      ST_CLEAR  = 4'd2,
      ST_SETTLE = 4'd3,
      ST_SAMPLE = 4'd4,
      ST_EVAL   = 4'd5,
      ST_MOVE   = 4'd6,
      ST_DONE   = 4'd7,
      ST_FAIL   = 4'd8
   } state_t;

   // Number of ones in one 2-bit RX sample.
   function automatic logic [1:0] popcount2(input logic [1:0] bits);
      return {1'b0, bits[1]} + {1'b0, bits[0]};
   endfunction

   state_t              state_q, state_d;
   logic [7:0]          tap_q, tap_d;
   logic                seen_zero_q, seen_zero_d;
   logic [ONES_W-1:0]   ones_q, ones_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [7:0]          tap_result_q, tap_result_d;
   logic [1:0]          eye_flags_q, eye_flags_d;
   logic                load_q, load_d;
   logic                move_q, move_d;
   logic                dir_q, dir_d;
   logic                clr_q, clr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                fail_q, fail_d;
   logic                value_s;

   // Next-state logic: sweep sequencing, sample accumulation and tap decision.
   always_comb begin
      state_d      = state_q;
      tap_d        = tap_q;
      seen_zero_d  = seen_zero_q;
      ones_d       = ones_q;
      cnt_d        = cnt_q;
      tap_result_d = tap_result_q;
      eye_flags_d  = eye_flags_q;
      value_s      = (ones_q > ONES_THRESH);
      if (ABORT) begin
         // Abort leaves the delay line where it is; no reload is issued.
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (START) begin
                  state_d      = ST_LOAD;
                  tap_d        = 8'd0;
                  seen_zero_d  = 1'b0;
                  ones_d       = {ONES_W{1'b0}};
                  cnt_d        = {CNT_W{1'b0}};
                  tap_result_d = 8'd0;
               end else begin
                  state_d = state_q;
               end
            end
            ST_LOAD: begin
               state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
               ones_d  = {ONES_W{1'b0}};
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_d   = {CNT_W{1'b0}};
                  state_d = ST_SAMPLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_SAMPLE: begin
               ones_d = ones_q + ONES_W'(popcount2(RX_DATA_0));
               if (cnt_q == SAMPLE_LAST) begin
                  cnt_d   = {CNT_W{1'b0}};
                  state_d = ST_EVAL;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_EVAL: begin
               eye_flags_d = {EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0};
               if (value_s && seen_zero_q) begin
                  state_d      = ST_DONE;
                  tap_result_d = tap_q;
               end else if (DELAY_LINE_OUT_OF_RANGE_0 || (tap_q == LAST_TAP)) begin
                  // Checked before the increment so the tap counter never wraps.
                  state_d = ST_FAIL;
               end else begin
                  if (!value_s) begin
                     seen_zero_d = 1'b1;
                  end else begin
                     seen_zero_d = seen_zero_q;
                  end
                  state_d = ST_MOVE;
               end
            end
            ST_MOVE: begin
               tap_d   = tap_q + 8'd1;
               state_d = ST_CLEAR;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode from the next state so every output comes straight off a flop.
   always_comb begin
      busy_d = (state_d == ST_LOAD)   || (state_d == ST_CLEAR) ||
               (state_d == ST_SETTLE) || (state_d == ST_SAMPLE) ||
               (state_d == ST_EVAL)   || (state_d == ST_MOVE);
      load_d = (state_d == ST_LOAD);
      move_d = (state_d == ST_MOVE);
      clr_d  = (state_d == ST_CLEAR);
      dir_d  = busy_d;
      done_d = (state_d == ST_DONE);
      fail_d = (state_d == ST_FAIL);
   end

   // State, datapath and output registers.
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         state_q      <= ST_IDLE;
         tap_q        <= 8'd0;
         seen_zero_q  <= 1'b0;
         ones_q       <= {ONES_W{1'b0}};
         cnt_q        <= {CNT_W{1'b0}};
         tap_result_q <= 8'd0;
         eye_flags_q  <= 2'b00;
         load_q       <= 1'b0;
         move_q       <= 1'b0;
         dir_q        <= 1'b0;
         clr_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tap_q        <= tap_d;
         seen_zero_q  <= seen_zero_d;
         ones_q       <= ones_d;
         cnt_q        <= cnt_d;
         tap_result_q <= tap_result_d;
         eye_flags_q  <= eye_flags_d;
         load_q       <= load_d;
         move_q       <= move_d;
         dir_q        <= dir_d;
         clr_q        <= clr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
      end
   end

   assign DELAY_LINE_LOAD_0         = load_q;
   assign DELAY_LINE_MOVE_0         = move_q;
   assign DELAY_LINE_DIRECTION_0    = dir_q;
   assign EYE_MONITOR_CLEAR_FLAGS_0 = clr_q;
   assign BUSY                      = busy_q;
   assign DONE                      = done_q;
   assign FAIL                      = fail_q;
   assign TAP_RESULT                = tap_result_q;
   assign EYE_FLAGS                 = eye_flags_q;

endmodule

// File: tb/tb_dqsw_delay_trainer.sv
// Bench for dqsw_delay_trainer: an IOD responder plus a sweep-plan model
// checked against the DUT every cycle, and directed scenario checks.
module tb_dqsw_delay_trainer;

   localparam int MAX_TAPS = 128;
   localparam int S        = 8;
   localparam int N        = 4;
   localparam int P        = S + N + 3;

   logic       FAB_CLK = 1'b0;
   logic       ARST_N  = 1'b0;
   logic       START   = 1'b0;
   logic       ABORT   = 1'b0;
   logic [1:0] rx      = 2'b00;
   logic       oor     = 1'b0;
   logic       early   = 1'b0;
   logic       late    = 1'b0;
   logic       load, move, dir, clr, busy, done, fail;
   logic [7:0] tap_result;
   logic [1:0] eye_flags;

   dqsw_delay_trainer #(.MAX_TAPS(MAX_TAPS), .SETTLE_CYCLES(S), .SAMPLES(N)) dut (
      .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .START(START), .ABORT(ABORT),
      .RX_DATA_0(rx), .DELAY_LINE_OUT_OF_RANGE_0(oor),
      .EYE_MONITOR_EARLY_0(early), .EYE_MONITOR_LATE_0(late),
      .DELAY_LINE_LOAD_0(load), .DELAY_LINE_MOVE_0(move),
      .DELAY_LINE_DIRECTION_0(dir), .EYE_MONITOR_CLEAR_FLAGS_0(clr),
      .BUSY(busy), .DONE(done), .FAIL(fail),
      .TAP_RESULT(tap_result), .EYE_FLAGS(eye_flags)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   int checks = 0;
   int errors = 0;
   int prints = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (prints < 40) begin
            prints++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
         end
      end
   endtask

   // Scenario: 0 edge at tap 5, 1 always one, 2 out-of-range from tap 3, 3 majority edge cases
   int scn = 0;

   function automatic logic [1:0] pat(input int sc, input int k, input int o);
      case (sc)
         1: return 2'b11;
         2: return 2'b00;
         3: begin
            if (k < 2) return 2'b00;
            else if (k == 2) return 2'b01;
            else if (k == 3) return (o == S + 1) ? 2'b11 : 2'b01;
            else return 2'b11;
         end
         default: return (k >= 5) ? 2'b11 : 2'b00;
      endcase
   endfunction

   function automatic int pop2(input logic [1:0] b);
      return int'(b[0]) + int'(b[1]);
   endfunction

   function automatic logic [1:0] eye_of(input int k);
      logic [7:0] t;
      t = k[7:0];
      return {t[0], t[1]};
   endfunction

   // Model: plan the whole sweep at START, then expected outputs by cycle arithmetic.
   localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAIL = 3;
   int         m_st = M_IDLE;
   int         m_c = 0;
   int         m_k = 0;
   int         m_e = 0;
   bit         m_found = 1'b0;
   logic [7:0] m_tr = 8'd0;
   logic [1:0] m_eye = 2'b00;

   task automatic plan();
      bit seen, fin, v;
      int ones;
      seen = 1'b0;
      fin  = 1'b0;
      for (int k = 0; k < MAX_TAPS; k++) begin
         if (!fin) begin
            ones = 0;
            for (int o = S + 1; o <= S + N; o++) ones += pop2(pat(scn, k, o));
            v = (ones > N);
            if (v && seen) begin
               m_k = k; m_found = 1'b1; fin = 1'b1;
            end else if ((scn == 2 && k >= 3) || k == MAX_TAPS - 1) begin
               m_k = k; m_found = 1'b0; fin = 1'b1;
            end else if (!v) begin
               seen = 1'b1;
            end
         end
      end
      m_e = 2 + m_k * P + S + N + 1;
   endtask

   function automatic bit is_eval(input int c);
      return (c >= 2) && (((c - 2) % P) == S + N + 1);
   endfunction

   always @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         m_st = M_IDLE; m_c = 0; m_tr = 8'd0; m_eye = 2'b00;
      end else if (ABORT) begin
         m_st = M_IDLE;
      end else if (m_st == M_RUN) begin
         if (is_eval(m_c)) m_eye = eye_of((m_c - 2) / P);
         m_c++;
         if (m_c == m_e + 1) begin
            m_st = m_found ? M_DONE : M_FAIL;
            m_tr = m_found ? m_k[7:0] : 8'd0;
         end
      end else if (START) begin
         plan();
         m_st = M_RUN; m_c = 1; m_tr = 8'd0;
      end
   end

   function automatic logic [16:0] model_vec();
      logic l, mv, c, b, d, f;
      int o;
      l = 1'b0; mv = 1'b0; c = 1'b0; b = 1'b0; d = 1'b0; f = 1'b0;
      if (m_st == M_RUN) begin
         b = 1'b1;
         l = (m_c == 1);
         if (m_c >= 2) begin
            o  = (m_c - 2) % P;
            c  = (o == 0);
            mv = (o == P - 1);
         end
      end else if (m_st == M_DONE) begin
         d = 1'b1;
      end else if (m_st == M_FAIL) begin
         f = 1'b1;
      end
      return {l, mv, b, c, b, d, f, m_tr, m_eye};
   endfunction

   // Per-cycle compare, strobe counting and IOD delay-line / DQ responder.
   int cnt_load = 0, cnt_move = 0, cnt_clr = 0;
   int iod_tap = 0, ofs = 0;

   always @(negedge FAB_CLK) begin
      check("cycle_outputs", 32'({load, move, dir, clr, busy, done, fail, tap_result, eye_flags}),
            32'(model_vec()));
      if (load && move) check("load_move_overlap", 32'd1, 32'd0);
      cnt_load += int'(load);
      cnt_move += int'(move);
      cnt_clr  += int'(clr);
      if (load) iod_tap = 0;
      else if (move) iod_tap++;
      if (clr) ofs = 0;
      else ofs++;
      rx    = pat(scn, iod_tap, ofs);
      oor   = (scn == 2) && (iod_tap >= 3);
      early = eye_of(iod_tap)[1];
      late  = eye_of(iod_tap)[0];
   end

   task automatic start_pulse();
      @(negedge FAB_CLK);
      START = 1'b1;
      cnt_load = 0; cnt_move = 0; cnt_clr = 0;
      @(negedge FAB_CLK);
      START = 1'b0;
   endtask

   task automatic wait_end(input int limit, output int n);
      n = 1;
      while (!(done || fail) && n < limit) begin
         @(negedge FAB_CLK);
         n++;
      end
      if (n >= limit) check("end_timeout", 32'(n), 32'(limit - 1));
   endtask

   int n;

   initial begin
      repeat (3) @(negedge FAB_CLK);
      check("reset_outputs", 32'({load, move, dir, clr, busy, done, fail, tap_result, eye_flags}), 32'd0);
      #2 ARST_N = 1'b1;

      // Edge at tap 5
      scn = 0;
      start_pulse();
      wait_end(200, n);
      check("s0_done_cycle", 32'(n), 32'd91);
      check("s0_done", 32'(done), 32'd1);
      check("s0_tap", 32'(tap_result), 32'd5);
      check("s0_moves", 32'(cnt_move), 32'd5);
      check("s0_loads", 32'(cnt_load), 32'd1);
      check("s0_clears", 32'(cnt_clr), 32'd6);
      check("s0_eye", 32'(eye_flags), 32'd2);

      // DQ always one: sweep exhausted
      scn = 1;
      start_pulse();
      wait_end(3000, n);
      check("s1_fail_cycle", 32'(n), 32'd1921);
      check("s1_fail", 32'(fail), 32'd1);
      check("s1_tap", 32'(tap_result), 32'd0);
      check("s1_moves", 32'(cnt_move), 32'd127);

      // Out-of-range from tap 3
      scn = 2;
      start_pulse();
      wait_end(200, n);
      check("s2_fail_cycle", 32'(n), 32'd61);
      check("s2_fail", 32'(fail), 32'd1);
      check("s2_moves", 32'(cnt_move), 32'd3);

      // Majority: tie at tap 2 reads 0, 5/8 at tap 3 reads 1
      scn = 3;
      start_pulse();
      wait_end(200, n);
      check("s3_done_cycle", 32'(n), 32'd61);
      check("s3_done", 32'(done), 32'd1);
      check("s3_tap", 32'(tap_result), 32'd3);
      check("s3_eye", 32'(eye_flags), 32'd3);

      // Asynchronous reset in SAMPLE of tap 0
      scn = 0;
      start_pulse();
      repeat (11) @(negedge FAB_CLK);
      #2 ARST_N = 1'b0;
      #1 check("async_reset", 32'({load, move, dir, clr, busy, done, fail, tap_result, eye_flags}), 32'd0);
      @(negedge FAB_CLK);
      #2 ARST_N = 1'b1;
      repeat (20) @(negedge FAB_CLK);
      check("idle_after_reset", 32'({busy, done, fail, cnt_load}), 32'd1);

      // Abort in SETTLE of tap 2, with ignored START mid-sweep
      start_pulse();
      n = 1;
      while (n < 35) begin
         @(negedge FAB_CLK);
         n++;
         START = (n == 10);
      end
      ABORT = 1'b1;
      START = 1'b1;
      @(negedge FAB_CLK);
      ABORT = 1'b0;
      START = 1'b0;
      check("abort_idle", 32'({busy, done, fail}), 32'd0);
      check("abort_moves", 32'(cnt_move), 32'd2);
      check("abort_loads", 32'(cnt_load), 32'd1);
      repeat (3) @(negedge FAB_CLK);
      check("abort_stays_idle", 32'({busy, load}), 32'd0);
      start_pulse();
      wait_end(200, n);
      check("rerun_done_cycle", 32'(n), 32'd91);
      check("rerun_tap", 32'(tap_result), 32'd5);
      check("rerun_moves", 32'(cnt_move), 32'd5);

      repeat (2) @(negedge FAB_CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
